dcache_req_buffer: RTL and testbench

// - Stage directly downstream of the load/store translation FSM: captures one translated memory op on mem_req_valid_i,

---
 rtl/dcache_req_pkg.sv | 14 +
 rtl/dcache_req_align.sv | 27 ++
 rtl/dcache_req_buffer.sv | 153 +++++++++++++++
 tb/tb_dcache_req_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_req_pkg.sv
// dcache_req_pkg: shared size encodings, FSM state encoding and byte-enable helper for the dcache request buffer.
package dcache_req_pkg;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DRAIN} state_e;

    // Unshifted byte-enable mask for an access of the given size: (1 << (1 << size)) - 1.
    function automatic logic [7:0] size_be(input logic [1:0] size);
        return 8'((9'd1 << (4'd1 << size)) - 9'd1);
    endfunction
endpackage

// File: rtl/dcache_req_align.sv
// dcache_req_align: combinational lane alignment for the dcache request buffer.
//   st_off_i/st_size_i/st_data_i -> be_o, wdata_o, misaligned_o (store side and alignment check of a new op)
//   ld_off_i/ld_size_i/rdata_i   -> ld_data_o (LSB-aligned, zero-extended load data)
module dcache_req_align
    import dcache_req_pkg::*;
#(
    parameter int DATA_W = 64,
    localparam int BE_W = DATA_W / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [OFF_W-1:0]  st_off_i,
    input  logic [1:0]        st_size_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [OFF_W-1:0]  ld_off_i,
    input  logic [1:0]        ld_size_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              misaligned_o
);
    assign be_o         = BE_W'(size_be(st_size_i)) << st_off_i;
    assign wdata_o      = st_data_i << {st_off_i, 3'b000};
    // A dword mask shifts 1 past the top bit, wraps to 0, and the -1 yields all ones.
    assign ld_data_o    = (rdata_i >> {ld_off_i, 3'b000}) & ((DATA_W'(1) << (8 << ld_size_i)) - DATA_W'(1));
    assign misaligned_o = |(st_off_i & OFF_W'((4'd1 << st_size_i) - 4'd1));
endmodule

// File: rtl/dcache_req_buffer.sv
// dcache_req_buffer: single-outstanding load/store buffer between the translation FSM and the data cache.
module dcache_req_buffer
  import dcache_req_pkg::*;
#(
  parameter int PADDR_W     = 40,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_req_valid_i,
  input  logic                is_store_i,
  input  logic                kill_mem_op_i,
  input  logic [PADDR_W-1:0]  paddr_i,
  input  logic [1:0]          size_i,
  input  logic [DATA_W-1:0]   st_data_i,
  output logic                dcache_req_valid_o,
  output logic                dcache_req_we_o,
  output logic [PADDR_W-1:0]  dcache_req_addr_o,
  output logic [DATA_W/8-1:0] dcache_req_be_o,
  output logic [DATA_W-1:0]   dcache_req_wdata_o,
  input  logic                dcache_req_gnt_i,
  input  logic                dcache_rsp_valid_i,
  input  logic [DATA_W-1:0]   dcache_rsp_rdata_i,
  output logic                ld_resp_valid_o,
  output logic [DATA_W-1:0]   ld_data_o,
  output logic                st_resp_gnt_o,
  output logic                misaligned_o,
  output logic                timeout_o,
  output logic                busy_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  state_e             state_q;
  logic               valid_q, we_q, killed_q, ld_valid_q, st_gnt_q, mis_q;
  logic [PADDR_W-1:0] addr_q;
  logic [1:0]         size_q;
  logic [BE_W-1:0]    be_q, be;
  logic [DATA_W-1:0]  wdata_q, ld_data_q, wdata, ld_data;
  logic               mis, kill_eff;
  assign kill_eff = killed_q | kill_mem_op_i;
  dcache_req_align #(.DATA_W(DATA_W)) u_align (
    .st_off_i     (paddr_i[OFF_W-1:0]),
    .st_size_i    (size_i),
    .st_data_i    (st_data_i),
    .ld_off_i     (addr_q[OFF_W-1:0]),
    .ld_size_i    (size_q),
    .rdata_i      (dcache_rsp_rdata_i),
    .be_o         (be),
    .wdata_o      (wdata),
    .ld_data_o    (ld_data),
    .misaligned_o (mis)
  );
`ifdef DCACHE_REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] timer_q;
  logic          timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      killed_q   <= 1'b0;
      ld_valid_q <= 1'b0;
      st_gnt_q   <= 1'b0;
      mis_q      <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      ld_data_q  <= '0;
`ifdef DCACHE_REQ_TIMEOUT_EN
      timer_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      ld_valid_q <= 1'b0;
      st_gnt_q   <= 1'b0;
      mis_q      <= 1'b0;
      unique case (state_q)
        IDLE: if (mem_req_valid_i && !kill_mem_op_i) begin
          we_q     <= is_store_i;
          addr_q   <= paddr_i;
          size_q   <= size_i;
          be_q     <= be;
          wdata_q  <= wdata;
          killed_q <= 1'b0;
          if (mis) begin
            mis_q      <= 1'b1;
            ld_valid_q <= !is_store_i;
            st_gnt_q   <= is_store_i;
            if (!is_store_i) ld_data_q <= '0;
          end else begin
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (kill_mem_op_i) killed_q <= 1'b1;
          if (dcache_req_gnt_i) begin
            valid_q <= 1'b0;
            if (we_q) begin
              st_gnt_q <= !kill_eff;
              state_q  <= IDLE;
            end else begin
              state_q <= kill_eff ? DRAIN : WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (dcache_rsp_valid_i) begin
            ld_valid_q <= !kill_mem_op_i;
            if (!kill_mem_op_i) ld_data_q <= ld_data;
            state_q <= IDLE;
          end else if (kill_mem_op_i) begin
            killed_q <= 1'b1;
            state_q  <= DRAIN;
          end
        end
        DRAIN: if (dcache_rsp_valid_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifdef DCACHE_REQ_TIMEOUT_EN
      timeout_q <= 1'b0;
      if (state_q != IDLE && timer_q == TW'(TIMEOUT_CYC - 1)) begin
        state_q    <= IDLE;
        valid_q    <= 1'b0;
        timeout_q  <= 1'b1;
        timer_q    <= '0;
        st_gnt_q   <= we_q && !kill_eff;
        ld_valid_q <= !we_q && !kill_eff;
        if (!we_q && !kill_eff) ld_data_q <= '0;
      end else begin
        timer_q <= (state_q != IDLE) ? timer_q + 1'b1 : '0;
      end
`endif
    end
  end
  assign dcache_req_valid_o = valid_q;
  assign dcache_req_we_o    = we_q;
  assign dcache_req_addr_o  = addr_q;
  assign dcache_req_be_o    = be_q;
  assign dcache_req_wdata_o = wdata_q;
  assign ld_resp_valid_o    = ld_valid_q;
  assign ld_data_o          = ld_data_q;
  assign st_resp_gnt_o      = st_gnt_q;
  assign misaligned_o       = mis_q;
  assign busy_o             = state_q != IDLE;
endmodule

// File: tb/tb_dcache_req_buffer.sv
// tb_dcache_req_buffer: table-driven and directed checks of the dcache request buffer.
module tb_dcache_req_buffer;
  import dcache_req_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_req_valid_i = 1'b0, is_store_i = 1'b0, kill_mem_op_i = 1'b0;
  logic [39:0] paddr_i = '0;
  logic [1:0]  size_i = '0;
  logic [63:0] st_data_i = '0;
  logic        dcache_req_gnt_i = 1'b0, dcache_rsp_valid_i = 1'b0;
  logic [63:0] dcache_rsp_rdata_i = '0;
  logic        dcache_req_valid_o, dcache_req_we_o;
  logic [39:0] dcache_req_addr_o;
  logic [7:0]  dcache_req_be_o;
  logic [63:0] dcache_req_wdata_o, ld_data_o;
  logic        ld_resp_valid_o, st_resp_gnt_o, misaligned_o, timeout_o, busy_o;
  int          pass_cnt = 0, tot_cnt = 0;
  logic [63:0] last_ld = '0;
  always #5 clk = ~clk;
  dcache_req_buffer #(.TIMEOUT_CYC(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_req_valid_i    (mem_req_valid_i),
    .is_store_i         (is_store_i),
    .kill_mem_op_i      (kill_mem_op_i),
    .paddr_i            (paddr_i),
    .size_i             (size_i),
    .st_data_i          (st_data_i),
    .dcache_req_valid_o (dcache_req_valid_o),
    .dcache_req_we_o    (dcache_req_we_o),
    .dcache_req_addr_o  (dcache_req_addr_o),
    .dcache_req_be_o    (dcache_req_be_o),
    .dcache_req_wdata_o (dcache_req_wdata_o),
    .dcache_req_gnt_i   (dcache_req_gnt_i),
    .dcache_rsp_valid_i (dcache_rsp_valid_i),
    .dcache_rsp_rdata_i (dcache_rsp_rdata_i),
    .ld_resp_valid_o    (ld_resp_valid_o),
    .ld_data_o          (ld_data_o),
    .st_resp_gnt_o      (st_resp_gnt_o),
    .misaligned_o       (misaligned_o),
    .timeout_o          (timeout_o),
    .busy_o             (busy_o)
  );
  typedef struct {
    logic        st;
    logic [39:0] addr;
    logic [1:0]  sz;
    logic [63:0] sd;
    logic [63:0] rd;
    int          dly;
    logic [7:0]  be;
    logic [63:0] wd;
    logic [63:0] ld;
    logic        mis;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic st, input logic [39:0] a, input logic [1:0] sz, input logic [63:0] sd);
    mem_req_valid_i = 1'b1;
    is_store_i = st;
    paddr_i = a;
    size_i = sz;
    st_data_i = sd;
    tick();
    mem_req_valid_i = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    issue(v.st, v.addr, v.sz, v.sd);
    if (v.mis) begin
      chk("mis_no_req", dcache_req_valid_o, 0);
      chk("mis_pulse", misaligned_o, 1);
      chk("mis_ld_valid", ld_resp_valid_o, !v.st);
      chk("mis_st_gnt", st_resp_gnt_o, v.st);
      chk("mis_busy", busy_o, 0);
      if (!v.st) last_ld = '0;
      chk("mis_ld_data", ld_data_o, last_ld);
    end else begin
      chk("req_valid", dcache_req_valid_o, 1);
      chk("req_we", dcache_req_we_o, v.st);
      chk("req_addr", dcache_req_addr_o, v.addr);
      chk("req_be", dcache_req_be_o, v.be);
      if (v.st) chk("req_wdata", dcache_req_wdata_o, v.wd);
      for (int i = 0; i < v.dly; i++) begin
        tick();
        chk("hold_valid", dcache_req_valid_o, 1);
        chk("hold_be", dcache_req_be_o, v.be);
      end
      dcache_req_gnt_i = 1'b1;
      tick();
      dcache_req_gnt_i = 1'b0;
      chk("gnt_drop_valid", dcache_req_valid_o, 0);
      chk("no_mis", misaligned_o, 0);
      if (v.st) begin
        chk("st_gnt_pulse", st_resp_gnt_o, 1);
        chk("st_busy_done", busy_o, 0);
        chk("ld_data_hold", ld_data_o, last_ld);
      end else begin
        chk("ld_wait_busy", busy_o, 1);
        tick();
        chk("ld_no_early", ld_resp_valid_o, 0);
        dcache_rsp_valid_i = 1'b1;
        dcache_rsp_rdata_i = v.rd;
        tick();
        dcache_rsp_valid_i = 1'b0;
        chk("ld_valid_pulse", ld_resp_valid_o, 1);
        last_ld = v.ld;
        chk("ld_data", ld_data_o, v.ld);
        chk("ld_busy_done", busy_o, 0);
      end
    end
    tick();
    chk("pulses_end", {61'd0, ld_resp_valid_o, st_resp_gnt_o, misaligned_o}, 0);
  endtask
  initial begin
    vt[0] = '{1'b1, 40'h10_0000_0004, SZ_WORD,  64'hDEADBEEF,            64'h0, 2, 8'hF0, 64'hDEADBEEF_00000000, 64'h0, 1'b0};
    vt[1] = '{1'b0, 40'h10_0000_0006, SZ_HALF,  64'h0, 64'hABCD_0000_0000_0000, 1, 8'hC0, 64'h0, 64'hABCD, 1'b0};
    vt[2] = '{1'b0, 40'h10_0000_0004, SZ_DWORD, 64'h0,                   64'h0, 0, 8'h00, 64'h0, 64'h0, 1'b1};
    vt[3] = '{1'b1, 40'h10_0000_0003, SZ_BYTE,  64'hA5,                  64'h0, 0, 8'h08, 64'h0000_0000_A500_0000, 64'h0, 1'b0};
    vt[4] = '{1'b0, 40'h10_0000_0005, SZ_BYTE,  64'h0, 64'h0011_2233_4455_6677, 0, 8'h20, 64'h0, 64'h22, 1'b0};
    vt[5] = '{1'b0, 40'h10_0000_0000, SZ_DWORD, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
    vt[6] = '{1'b1, 40'h10_0000_0001, SZ_HALF,  64'h1234,                64'h0, 0, 8'h00, 64'h0, 64'h0, 1'b1};
    vt[7] = '{1'b1, 40'h10_0000_0008, SZ_DWORD, 64'hCAFE_F00D_1234_5678, 64'h0, 0, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0};
    vt[8] = '{1'b0, 40'h10_0000_0004, SZ_WORD,  64'h0, 64'h89AB_CDEF_0123_4567, 1, 8'hF0, 64'h0, 64'h89AB_CDEF, 1'b0};
    #1;
    chk("rst_valid", dcache_req_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_be", dcache_req_be_o, 0);
    chk("rst_addr", dcache_req_addr_o, 0);
    chk("rst_ld_data", ld_data_o, 0);
    tick();
    rst = 1'b0;
    tick();
    foreach (vt[i]) run_vec(vt[i]);
    mem_req_valid_i = 1'b1;
    kill_mem_op_i = 1'b1;
    is_store_i = 1'b1;
    paddr_i = 40'h20;
    size_i = SZ_WORD;
    tick();
    mem_req_valid_i = 1'b0;
    kill_mem_op_i = 1'b0;
    chk("killreq_busy", busy_o, 0);
    chk("killreq_valid", dcache_req_valid_o, 0);
    tick();
    chk("killreq_no_pulse", {62'd0, st_resp_gnt_o, misaligned_o}, 0);
    issue(1'b1, 40'h30, SZ_WORD, 64'h1122_3344);
    kill_mem_op_i = 1'b1;
    tick();
    kill_mem_op_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("kiss_valid", dcache_req_valid_o, 1);
      chk("kiss_addr", dcache_req_addr_o, 40'h30);
      chk("kiss_wdata", dcache_req_wdata_o, 64'h1122_3344);
      tick();
    end
    chk("kiss_valid_last", dcache_req_valid_o, 1);
    dcache_req_gnt_i = 1'b1;
    tick();
    dcache_req_gnt_i = 1'b0;
    chk("kiss_drop", dcache_req_valid_o, 0);
    chk("kiss_no_gnt", st_resp_gnt_o, 0);
    chk("kiss_idle", busy_o, 0);
    issue(1'b0, 40'h48, SZ_DWORD, 64'h0);
    dcache_req_gnt_i = 1'b1;
    kill_mem_op_i = 1'b1;
    tick();
    dcache_req_gnt_i = 1'b0;
    kill_mem_op_i = 1'b0;
    chk("kgnt_busy", busy_o, 1);
    dcache_rsp_valid_i = 1'b1;
    dcache_rsp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dcache_rsp_valid_i = 1'b0;
    chk("kgnt_no_ld", ld_resp_valid_o, 0);
    chk("kgnt_idle", busy_o, 0);
    chk("kgnt_ld_hold", ld_data_o, last_ld);
    issue(1'b0, 40'h40, SZ_WORD, 64'h0);
    dcache_req_gnt_i = 1'b1;
    tick();
    dcache_req_gnt_i = 1'b0;
    kill_mem_op_i = 1'b1;
    tick();
    kill_mem_op_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("kwr_busy", busy_o, 1);
      chk("kwr_no_ld", ld_resp_valid_o, 0);
      tick();
    end
    dcache_rsp_valid_i = 1'b1;
    dcache_rsp_rdata_i = 64'h5555_6666_7777_8888;
    tick();
    dcache_rsp_valid_i = 1'b0;
    chk("kwr_no_ld_rsp", ld_resp_valid_o, 0);
    chk("kwr_idle", busy_o, 0);
    chk("kwr_ld_hold", ld_data_o, last_ld);
    run_vec(vt[8]);
`ifdef DCACHE_REQ_TIMEOUT_EN
    issue(1'b0, 40'h50, SZ_WORD, 64'h0);
    for (int i = 1; i < 8; i++) begin
      chk("to_wait", timeout_o, 0);
      tick();
    end
    chk("to_wait_last", timeout_o, 0);
    tick();
    chk("to_pulse", timeout_o, 1);
    chk("to_ld_valid", ld_resp_valid_o, 1);
    chk("to_ld_data", ld_data_o, 0);
    chk("to_valid", dcache_req_valid_o, 0);
    chk("to_idle", busy_o, 0);
    last_ld = '0;
    tick();
    chk("to_pulse_end", timeout_o, 0);
`else
    issue(1'b1, 40'h58, SZ_DWORD, 64'h77);
    for (int i = 0; i < 20; i++) begin
      chk("nto_timeout", timeout_o, 0);
      tick();
    end
    chk("nto_valid", dcache_req_valid_o, 1);
    chk("nto_busy", busy_o, 1);
    dcache_req_gnt_i = 1'b1;
    tick();
    dcache_req_gnt_i = 1'b0;
    chk("nto_st_gnt", st_resp_gnt_o, 1);
`endif
    issue(1'b1, 40'h68, SZ_WORD, 64'h9999_AAAA);
    chk("amid_valid", dcache_req_valid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", dcache_req_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_addr", dcache_req_addr_o, 0);
    chk("arst_be", dcache_req_be_o, 0);
    chk("arst_wdata", dcache_req_wdata_o, 0);
    chk("arst_we", dcache_req_we_o, 0);
    chk("arst_ld_data", ld_data_o, 0);
    rst = 1'b0;
    tick();
    chk("arst_stay_idle", busy_o, 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
